// File: rtl/mat_lsu_row_seq.sv
// Matrix LSU row sequencer: splits a strided matrix load/store into memory beats,
// bounds the issued-but-unacked beats and raises one completion pulse per request.
module mat_lsu_row_seq #(
    parameter int unsigned BEAT_BYTES = 64,
    parameter int unsigned MAX_OUTST  = 8
) (
    input  logic                        forever_cpuclk,
    input  logic                        cpurst_b,
    input  logic                        rtu_yy_xx_flush,
    input  logic                        req_vld,
    output logic                        req_rdy,
    input  logic [6:0]                  req_iid,
    input  logic                        req_st,
    input  logic [2:0]                  req_mreg,
    input  logic [63:0]                 req_base,
    input  logic [63:0]                 req_stride,
    input  logic [7:0]                  req_rows,
    input  logic [15:0]                 req_row_bytes,
    output logic                        beat_vld,
    input  logic                        beat_rdy,
    output logic [63:0]                 beat_addr,
    output logic [$clog2(BEAT_BYTES):0] beat_bytes,
    output logic [7:0]                  beat_row,
    output logic                        beat_st,
    output logic [2:0]                  beat_mreg,
    input  logic                        beat_ack,
    output logic                        mat_lsu_cbus_pipe8_sel,
    output logic [6:0]                  mat_lsu_cbus_pipe8_iid
);

    localparam int unsigned BB_W = $clog2(BEAT_BYTES) + 1;
    localparam int unsigned OW   = $clog2(MAX_OUTST + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [6:0]      cap_iid;
    logic            cap_st;
    logic [2:0]      cap_mreg;
    logic [63:0]     cap_stride;
    logic [7:0]      cap_rows;
    logic [15:0]     cap_row_bytes;

    logic [63:0]     row_base;
    logic [15:0]     beat_off;
    logic [7:0]      row;
    logic [OW-1:0]   outst;
    logic [OW-1:0]   outst_nxt;
    logic            sel_q;
    logic [6:0]      iid_q;

    logic            accept;
    logic            fire;
    logic            ack_hit;
    logic [15:0]     rem;
    logic            last_beat;
    logic            last_row;

    assign accept    = req_vld && (state == S_IDLE) && !rtu_yy_xx_flush;
    assign fire      = beat_vld && beat_rdy;
    // An ack with nothing outstanding is stale (e.g. after a flush) and is dropped.
    assign ack_hit   = beat_ack && (outst != '0);
    assign rem       = cap_row_bytes - beat_off;
    assign last_beat = (rem <= 16'(BEAT_BYTES));
    assign last_row  = (({1'b0, row} + 9'd1) == {1'b0, cap_rows});
    assign outst_nxt = (fire && !ack_hit) ? outst + OW'(1) :
                       (!fire && ack_hit) ? outst - OW'(1) : outst;

    // State register.
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush overrides every other event.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = ((req_rows == 8'd0) || (req_row_bytes == 16'd0)) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (fire && last_beat && last_row) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (outst == '0) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (rtu_yy_xx_flush) begin
            state_nxt = S_IDLE;
        end
    end

    // Outputs, all derived from registered state.
    always_comb begin
        req_rdy                = 1'b0;
        beat_vld               = 1'b0;
        beat_addr              = row_base + 64'(beat_off);
        beat_bytes             = last_beat ? BB_W'(rem) : BB_W'(BEAT_BYTES);
        beat_row               = row;
        beat_st                = cap_st;
        beat_mreg              = cap_mreg;
        mat_lsu_cbus_pipe8_sel = sel_q;
        mat_lsu_cbus_pipe8_iid = iid_q;
        if (state == S_IDLE) begin
            req_rdy = 1'b1;
        end
        if ((state == S_ISSUE) && (outst < OW'(MAX_OUTST))) begin
            beat_vld = 1'b1;
        end
    end

    // Request capture, beat walk and outstanding tracking.
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            cap_iid       <= '0;
            cap_st        <= 1'b0;
            cap_mreg      <= '0;
            cap_stride    <= '0;
            cap_rows      <= '0;
            cap_row_bytes <= '0;
            row_base      <= '0;
            beat_off      <= '0;
            row           <= '0;
            outst         <= '0;
        end else if (rtu_yy_xx_flush) begin
            beat_off <= '0;
            row      <= '0;
            outst    <= '0;
        end else if (accept) begin
            cap_iid       <= req_iid;
            cap_st        <= req_st;
            cap_mreg      <= req_mreg;
            cap_stride    <= req_stride;
            cap_rows      <= req_rows;
            cap_row_bytes <= req_row_bytes;
            row_base      <= req_base;
            beat_off      <= '0;
            row           <= '0;
            outst         <= '0;
        end else begin
            if (fire) begin
                if (last_beat) begin
                    beat_off <= '0;
                    row      <= row + 8'd1;
                    row_base <= row_base + cap_stride;
                end else begin
                    beat_off <= beat_off + 16'(BEAT_BYTES);
                end
            end
            outst <= outst_nxt;
        end
    end

    // Completion pulse lands the cycle after DONE.
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            sel_q <= 1'b0;
            iid_q <= '0;
        end else if (rtu_yy_xx_flush) begin
            sel_q <= 1'b0;
        end else begin
            sel_q <= (state == S_DONE);
            if (state == S_DONE) begin
                iid_q <= cap_iid;
            end
        end
    end

endmodule

// File: tb/tb_mat_lsu_row_seq.sv
// Bench for mat_lsu_row_seq: a per-cycle reference model built from the beat-list
// arithmetic, plus directed scenarios with hand-computed expectations.
module tb_mat_lsu_row_seq;

    localparam int unsigned BB = 64;
    localparam int unsigned MO = 8;
    localparam int PH_IDLE  = 0;
    localparam int PH_ISS   = 1;
    localparam int PH_DRAIN = 2;
    localparam int PH_DONE  = 3;

    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  bytes;
        logic [7:0]  row;
    } beat_t;

    logic        clk = 1'b0;
    logic        cpurst_b = 1'b0;
    logic        flush = 1'b0;
    logic        req_vld = 1'b0;
    logic        req_rdy;
    logic [6:0]  req_iid = '0;
    logic        req_st = 1'b0;
    logic [2:0]  req_mreg = '0;
    logic [63:0] req_base = '0;
    logic [63:0] req_stride = '0;
    logic [7:0]  req_rows = '0;
    logic [15:0] req_row_bytes = '0;
    logic        beat_vld;
    logic        beat_rdy = 1'b0;
    logic [63:0] beat_addr;
    logic [6:0]  beat_bytes;
    logic [7:0]  beat_row;
    logic        beat_st;
    logic [2:0]  beat_mreg;
    logic        beat_ack = 1'b0;
    logic        sel;
    logic [6:0]  sel_iid_o;

    mat_lsu_row_seq #(.BEAT_BYTES(BB), .MAX_OUTST(MO)) dut (
        .forever_cpuclk         (clk),
        .cpurst_b               (cpurst_b),
        .rtu_yy_xx_flush        (flush),
        .req_vld                (req_vld),
        .req_rdy                (req_rdy),
        .req_iid                (req_iid),
        .req_st                 (req_st),
        .req_mreg               (req_mreg),
        .req_base               (req_base),
        .req_stride             (req_stride),
        .req_rows               (req_rows),
        .req_row_bytes          (req_row_bytes),
        .beat_vld               (beat_vld),
        .beat_rdy               (beat_rdy),
        .beat_addr              (beat_addr),
        .beat_bytes             (beat_bytes),
        .beat_row               (beat_row),
        .beat_st                (beat_st),
        .beat_mreg              (beat_mreg),
        .beat_ack               (beat_ack),
        .mat_lsu_cbus_pipe8_sel (sel),
        .mat_lsu_cbus_pipe8_iid (sel_iid_o)
    );

    always #5 clk = ~clk;

    int chk_cnt = 0;
    int pass_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s got=%0h exp=%0h (t=%0t)", nm, got, exp, $time);
    endtask

    // Observation state shared with the stimulus driver.
    bit          mon_en = 1'b0;
    int          cyc = 0;
    beat_t       obs_q[$];
    bit          fire_seen = 1'b0;
    int          sel_cnt = 0;
    int          sel_cyc = 0;
    int          acc_cyc = 0;
    logic [6:0]  sel_iid_seen = '0;

    // Reference model state.
    int          m_ph = PH_IDLE;
    beat_t       m_q[$];
    int          m_outst = 0;
    bit          m_sel = 1'b0;
    logic [6:0]  m_sel_iid = '0;
    logic [6:0]  m_iid = '0;
    logic        m_st = 1'b0;
    logic [2:0]  m_mreg = '0;
    bit          exp_vld, m_fire, m_ack, sel_n;

    // Every beat of the request, straight from base + r*stride + k*BB.
    task automatic build_q(input logic [63:0] b, input logic [63:0] s, input int rows, input int rb);
        beat_t e;
        m_q.delete();
        for (int r = 0; r < rows; r++) begin
            for (int off = 0; off < rb; off += BB) begin
                e.addr  = b + 64'(r) * s + 64'(off);
                e.bytes = 8'(((rb - off) < int'(BB)) ? (rb - off) : int'(BB));
                e.row   = 8'(r);
                m_q.push_back(e);
            end
        end
    endtask

    // Compare process: check DUT against model, then advance model by one clock.
    always @(negedge clk) begin
        if (mon_en) begin
            cyc++;
            fire_seen = beat_vld && beat_rdy;
            if (fire_seen) obs_q.push_back('{beat_addr, {1'b0, beat_bytes}, beat_row});
            if (sel === 1'b1) begin
                sel_cnt++;
                sel_cyc = cyc;
                sel_iid_seen = sel_iid_o;
            end
            if (req_vld && req_rdy && !flush && cpurst_b) acc_cyc = cyc;

            exp_vld = (m_ph == PH_ISS) && (m_outst < int'(MO));
            chk("req_rdy", 64'(req_rdy), 64'(m_ph == PH_IDLE));
            chk("beat_vld", 64'(beat_vld), 64'(exp_vld));
            chk("sel", 64'(sel), 64'(m_sel));
            if (m_sel) chk("sel_iid", 64'(sel_iid_o), 64'(m_sel_iid));
            if (exp_vld && m_q.size() > 0) begin
                chk("beat_addr", beat_addr, m_q[0].addr);
                chk("beat_bytes", 64'(beat_bytes), 64'(m_q[0].bytes));
                chk("beat_row", 64'(beat_row), 64'(m_q[0].row));
                chk("beat_st_mreg", 64'({beat_st, beat_mreg}), 64'({m_st, m_mreg}));
            end

            if (!cpurst_b) begin
                m_ph = PH_IDLE;
                m_outst = 0;
                m_q.delete();
                m_sel = 1'b0;
            end else begin
                m_fire = exp_vld && beat_rdy;
                m_ack  = beat_ack && (m_outst > 0);
                sel_n  = (m_ph == PH_DONE) && !flush;
                if (sel_n) m_sel_iid = m_iid;
                if (flush) begin
                    m_ph = PH_IDLE;
                    m_outst = 0;
                    m_q.delete();
                end else begin
                    case (m_ph)
                        PH_ISS: begin
                            if (m_fire) begin
                                void'(m_q.pop_front());
                                if (m_q.size() == 0) m_ph = PH_DRAIN;
                            end
                        end
                        PH_DRAIN: if (m_outst == 0) m_ph = PH_DONE;
                        PH_DONE:  m_ph = PH_IDLE;
                        default: ;
                    endcase
                    m_outst = m_outst + (m_fire ? 1 : 0) - (m_ack ? 1 : 0);
                    if (m_ph == PH_IDLE && req_vld && !sel_n) begin
                        m_iid  = req_iid;
                        m_st   = req_st;
                        m_mreg = req_mreg;
                        build_q(req_base, req_stride, int'(req_rows), int'(req_row_bytes));
                        m_outst = 0;
                        m_ph = (m_q.size() == 0) ? PH_DONE : PH_ISS;
                    end
                end
                m_sel = sel_n;
            end
        end
    end

    // Memory-side driver: beat_rdy pattern and acks two cycles after each beat.
    int         rdy_mode = 0;
    bit         ack_auto = 1'b0;
    bit         man_ack = 1'b0;
    logic [1:0] ack_pipe = '0;

    always @(posedge clk) begin
        #2;
        ack_pipe = {ack_pipe[0], fire_seen};
        case (rdy_mode)
            0:       beat_rdy = 1'b1;
            1:       beat_rdy = ~beat_rdy;
            default: beat_rdy = 1'b0;
        endcase
        beat_ack = (ack_auto && ack_pipe[1]) || man_ack;
    end

    task automatic send_req(input logic [6:0] iid, input logic st, input logic [2:0] mreg,
                            input logic [63:0] base, input logic [63:0] stride,
                            input logic [7:0] rows, input logic [15:0] rb);
        @(posedge clk); #1;
        req_iid = iid; req_st = st; req_mreg = mreg; req_base = base;
        req_stride = stride; req_rows = rows; req_row_bytes = rb; req_vld = 1'b1;
        @(posedge clk); #1;
        req_vld = 1'b0;
    endtask

    task automatic wait_sel(input int max_cyc, input string nm);
        int start;
        bit got;
        start = sel_cnt;
        got = 1'b0;
        for (int i = 0; i < max_cyc && !got; i++) begin
            @(negedge clk); #1;
            if (sel_cnt != start) got = 1'b1;
        end
        chk(nm, 64'(got), 64'd1);
    endtask

    int  s0;
    bit  got;

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #1 mon_en = 1'b1;
        @(negedge clk); #1;
        chk("rst_req_rdy", 64'(req_rdy), 64'd1);
        chk("rst_beat_vld", 64'(beat_vld), 64'd0);
        chk("rst_sel", 64'(sel), 64'd0);
        chk("rst_addr", beat_addr, 64'd0);
        chk("rst_bytes_row", 64'({beat_bytes, beat_row}), 64'd0);
        chk("rst_iid_st_mreg", 64'({sel_iid_o, beat_st, beat_mreg}), 64'd0);
        @(posedge clk); #1 cpurst_b = 1'b1;

        // Two-row load, 100 bytes per row
        rdy_mode = 0; ack_auto = 1'b1; obs_q.delete();
        send_req(7'h15, 1'b0, 3'd3, 64'h1000, 64'h200, 8'd2, 16'd100);
        wait_sel(100, "load_done");
        chk("load_nbeats", 64'(obs_q.size()), 64'd4);
        if (obs_q.size() == 4) begin
            chk("load_b0", {obs_q[0].addr[31:0], obs_q[0].bytes, obs_q[0].row}, {32'h1000, 8'd64, 8'd0});
            chk("load_b1", {obs_q[1].addr[31:0], obs_q[1].bytes, obs_q[1].row}, {32'h1040, 8'd36, 8'd0});
            chk("load_b2", {obs_q[2].addr[31:0], obs_q[2].bytes, obs_q[2].row}, {32'h1200, 8'd64, 8'd1});
            chk("load_b3", {obs_q[3].addr[31:0], obs_q[3].bytes, obs_q[3].row}, {32'h1240, 8'd36, 8'd1});
        end
        chk("load_iid", 64'(sel_iid_seen), 64'h15);

        // Empty requests complete without beats
        obs_q.delete();
        send_req(7'h7f, 1'b1, 3'd5, 64'h3000, 64'h40, 8'd0, 16'd100);
        wait_sel(20, "rows0_done");
        chk("rows0_lat", 64'(sel_cyc - acc_cyc), 64'd2);
        chk("rows0_iid", 64'(sel_iid_seen), 64'h7f);
        send_req(7'h01, 1'b0, 3'd1, 64'h3000, 64'h40, 8'd4, 16'd0);
        wait_sel(20, "rb0_done");
        chk("rb0_lat", 64'(sel_cyc - acc_cyc), 64'd2);
        chk("empty_nbeats", 64'(obs_q.size()), 64'd0);

        // Outstanding limit with acks withheld
        ack_auto = 1'b0; obs_q.delete();
        send_req(7'h22, 1'b1, 3'd2, 64'h4000, 64'h0, 8'd1, 16'd1024);
        repeat (20) @(negedge clk);
        #1;
        chk("cap_nbeats", 64'(obs_q.size()), 64'd8);
        chk("cap_vld_low", 64'(beat_vld), 64'd0);
        @(posedge clk); #1 man_ack = 1'b1;
        repeat (4) @(posedge clk);
        #1 man_ack = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("cap_after_acks", 64'(obs_q.size()), 64'd12);
        chk("cap_vld_low2", 64'(beat_vld), 64'd0);
        @(posedge clk); #1 man_ack = 1'b1;
        wait_sel(100, "cap_done");
        man_ack = 1'b0;
        chk("cap_total", 64'(obs_q.size()), 64'd16);

        // Address wrap at 2^64
        ack_auto = 1'b1; obs_q.delete();
        send_req(7'h2a, 1'b0, 3'd0, 64'hFFFF_FFFF_FFFF_FFC0, 64'h40, 8'd2, 16'd64);
        wait_sel(50, "wrap_done");
        chk("wrap_nbeats", 64'(obs_q.size()), 64'd2);
        if (obs_q.size() == 2) begin
            chk("wrap_a0", obs_q[0].addr, 64'hFFFF_FFFF_FFFF_FFC0);
            chk("wrap_a1", obs_q[1].addr, 64'h0);
            chk("wrap_r1", 64'(obs_q[1].row), 64'd1);
        end

        // Flush with 3 beats outstanding; request in the flush cycle is ignored
        ack_auto = 1'b0; obs_q.delete(); s0 = sel_cnt;
        send_req(7'h33, 1'b0, 3'd4, 64'h5000, 64'h0, 8'd1, 16'd1024);
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk); #1;
            if (obs_q.size() >= 3) got = 1'b1;
        end
        chk("flush_setup", 64'(got), 64'd1);
        @(posedge clk); #1;
        rdy_mode = 2; flush = 1'b1;
        req_iid = 7'h44; req_rows = 8'd1; req_row_bytes = 16'd64; req_vld = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; req_vld = 1'b0; man_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1 man_ack = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("flush_no_sel", 64'(sel_cnt - s0), 64'd0);
        chk("flush_nbeats", 64'(obs_q.size()), 64'd3);
        rdy_mode = 0; ack_auto = 1'b1; obs_q.delete();
        send_req(7'h55, 1'b1, 3'd6, 64'h8000, 64'h0, 8'd1, 16'd64);
        wait_sel(40, "post_flush_done");
        chk("post_flush_beat", {obs_q.size() == 1, obs_q[0].addr, obs_q[0].bytes},
            {1'b1, 64'h8000, 8'd64});
        chk("post_flush_iid", 64'(sel_iid_seen), 64'h55);

        // beat_rdy toggling: stalls hold, nothing lost or duplicated
        rdy_mode = 1; obs_q.delete();
        send_req(7'h66, 1'b0, 3'd7, 64'h20000, 64'h100, 8'd3, 16'd130);
        wait_sel(200, "toggle_done");
        chk("toggle_nbeats", 64'(obs_q.size()), 64'd9);
        if (obs_q.size() == 9) begin
            chk("toggle_b4", {obs_q[4].addr, obs_q[4].bytes}, {64'h20140, 8'd64});
            chk("toggle_b8", {obs_q[8].addr, obs_q[8].bytes, obs_q[8].row}, {64'h20280, 8'd2, 8'd2});
        end

        // Reset mid-operation abandons the request
        rdy_mode = 0; obs_q.delete(); s0 = sel_cnt;
        send_req(7'h77, 1'b0, 3'd1, 64'h9000, 64'h1000, 8'd2, 16'd256);
        repeat (3) @(negedge clk);
        @(posedge clk); #1 cpurst_b = 1'b0;
        @(posedge clk); #1 cpurst_b = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        chk("rst_mid_no_sel", 64'(sel_cnt - s0), 64'd0);
        chk("rst_mid_partial", 64'(obs_q.size() < 8), 64'd1);
        chk("rst_mid_idle", 64'(req_rdy), 64'd1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
